// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU pin-protocol request issuer.
package fpu_pkg;

  localparam int DEF_LAT_ADD  = 7;
  localparam int DEF_LAT_MUL  = 12;
  localparam int DEF_LAT_DIV  = 35;
  localparam int DEF_LAT_SQRT = 35;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT, OP_NOP1, OP_NOP2, OP_NOP3
  } op_t;

  typedef enum logic [1:0] {
    RM_NEAREST, RM_ZERO, RM_UP, RM_DOWN
  } rmode_t;

  typedef struct packed {
    logic ine;
    logic overflow;
    logic underflow;
    logic div_zero;
    logic inf;
    logic zero;
    logic qnan;
    logic snan;
  } fpu_exc_t;

  typedef enum logic [1:0] {
    ST_OK, ST_BAD_OP, ST_TIMEOUT, ST_LAT_MISMATCH
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  function automatic logic [7:0] expected_latency(input op_t op, input int lat_add,
                                                  input int lat_mul, input int lat_div,
                                                  input int lat_sqrt);
    case (op)
      OP_ADD, OP_SUB: return 8'(lat_add);
      OP_MUL:         return 8'(lat_mul);
      OP_DIV:         return 8'(lat_div);
      OP_SQRT:        return 8'(lat_sqrt);
      default:        return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_req_issuer.sv
// Issues one FPU operation at a time, times its completion against the
// per-op latency and returns result, flags, latency and status.
module fpu_req_issuer
  import fpu_pkg::*;
#(
  parameter int FP_WIDTH  = 32,
  parameter int LAT_ADD   = DEF_LAT_ADD,
  parameter int LAT_MUL   = DEF_LAT_MUL,
  parameter int LAT_DIV   = DEF_LAT_DIV,
  parameter int LAT_SQRT  = DEF_LAT_SQRT,
  parameter int TIMEOUT   = 63,
  parameter int CHECK_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [FP_WIDTH-1:0] cmd_opa,
  input  logic [FP_WIDTH-1:0] cmd_opb,
  input  logic [2:0]          cmd_op,
  input  logic [1:0]          cmd_rmode,
  output logic [FP_WIDTH-1:0] fpu_opa,
  output logic [FP_WIDTH-1:0] fpu_opb,
  output logic [2:0]          fpu_op,
  output logic [1:0]          fpu_rmode,
  output logic                fpu_start,
  input  logic [FP_WIDTH-1:0] fpu_outp,
  input  logic                fpu_ready,
  input  logic [7:0]          fpu_exc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [FP_WIDTH-1:0] rsp_result,
  output logic [7:0]          rsp_exc,
  output logic [2:0]          rsp_op,
  output logic [7:0]          rsp_latency,
  output logic [1:0]          rsp_status,
  output logic                spurious_ready
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never drops and payload never changes until that transfer.

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t     state;
  op_t        op_q;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= OP_ADD;
      cnt            <= 8'd0;
      cmd_ready      <= 1'b1;
      fpu_opa        <= '0;
      fpu_opb        <= '0;
      fpu_op         <= 3'd0;
      fpu_rmode      <= 2'd0;
      fpu_start      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_exc        <= 8'd0;
      rsp_op         <= 3'd0;
      rsp_latency    <= 8'd0;
      rsp_status     <= 2'd0;
      spurious_ready <= 1'b0;
    end else begin
      if (fpu_ready && state != S_WAIT) spurious_ready <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op_q      <= op_t'(cmd_op);
            if (cmd_op > 3'd4) begin
              // Unsupported op codes never reach the FPU.
              rsp_result  <= '0;
              rsp_exc     <= 8'd0;
              rsp_op      <= cmd_op;
              rsp_latency <= 8'd0;
              rsp_status  <= ST_BAD_OP;
              rsp_valid   <= 1'b1;
              state       <= S_RESP;
            end else begin
              fpu_opa   <= cmd_opa;
              fpu_opb   <= cmd_opb;
              fpu_op    <= cmd_op;
              fpu_rmode <= cmd_rmode;
              fpu_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          fpu_start <= 1'b0;
          cnt       <= 8'd0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (fpu_ready) begin
            rsp_result  <= fpu_outp;
            rsp_exc     <= fpu_exc;
            rsp_op      <= op_q;
            rsp_latency <= cnt;
            rsp_status  <= (CHECK_LAT == 0 ||
                            cnt == expected_latency(op_q, LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT))
                           ? ST_OK : ST_LAT_MISMATCH;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (cnt == TIMEOUT_L - 8'd1) begin
            // This idle cycle is the TIMEOUT-th one: give up.
            rsp_result  <= '0;
            rsp_exc     <= 8'd0;
            rsp_op      <= op_q;
            rsp_latency <= TIMEOUT_L;
            rsp_status  <= ST_TIMEOUT;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_issuer.sv
// Randomized self-checking bench for fpu_req_issuer with a behavioural
// response model and an expected-response queue.
module tb_fpu_req_issuer;

  localparam int W       = 32;
  localparam int TMO     = 63;
  localparam int RW      = W + 8 + 3 + 8 + 2;
  localparam int S_OK    = 0;
  localparam int S_BAD   = 1;
  localparam int S_TMO   = 2;
  localparam int S_MISM  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [W-1:0] cmd_opa = '0, cmd_opb = '0;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_rmode = 2'd0;
  logic [W-1:0] fpu_outp = '0;
  logic fpu_ready = 1'b0;
  logic [7:0] fpu_exc = 8'd0;
  logic rsp_ready = 1'b0;

  logic cmd_ready, fpu_start, rsp_valid, spurious_ready;
  logic [W-1:0] fpu_opa, fpu_opb, rsp_result;
  logic [2:0] fpu_op, rsp_op;
  logic [1:0] fpu_rmode, rsp_status;
  logic [7:0] rsp_exc, rsp_latency;

  logic n_cmd_ready, n_fpu_start, n_rsp_valid, n_spurious;
  logic [W-1:0] n_fpu_opa, n_fpu_opb, n_rsp_result;
  logic [2:0] n_fpu_op, n_rsp_op;
  logic [1:0] n_fpu_rmode, n_rsp_status;
  logic [7:0] n_rsp_exc, n_rsp_latency;

  fpu_req_issuer #(.CHECK_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op), .cmd_rmode(cmd_rmode),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_start(fpu_start), .fpu_outp(fpu_outp), .fpu_ready(fpu_ready), .fpu_exc(fpu_exc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_exc(rsp_exc), .rsp_op(rsp_op), .rsp_latency(rsp_latency),
    .rsp_status(rsp_status), .spurious_ready(spurious_ready)
  );

  fpu_req_issuer #(.CHECK_LAT(0)) u_nochk (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op), .cmd_rmode(cmd_rmode),
    .fpu_opa(n_fpu_opa), .fpu_opb(n_fpu_opb), .fpu_op(n_fpu_op), .fpu_rmode(n_fpu_rmode),
    .fpu_start(n_fpu_start), .fpu_outp(fpu_outp), .fpu_ready(fpu_ready), .fpu_exc(fpu_exc),
    .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(n_rsp_result),
    .rsp_exc(n_rsp_exc), .rsp_op(n_rsp_op), .rsp_latency(n_rsp_latency),
    .rsp_status(n_rsp_status), .spurious_ready(n_spurious)
  );

  // Clock and cycle count.
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [1:0]    exp_nochk_q[$];
  logic          exp_spur = 1'b0;
  int            hs_cycle = 0;
  bit            have_hs = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int spec_latency(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 7;
      3'd2:       return 12;
      default:    return 35;
    endcase
  endfunction

  // Reference model: what the response must contain for a given FPU behaviour.
  task automatic predict(input logic [2:0] op, input int delay,
                         input logic [W-1:0] outp, input logic [7:0] exc);
    logic [RW-1:0] r;
    logic [1:0] nst;
    if (op >= 3'd5) begin
      r = {32'd0, 8'd0, op, 8'd0, 2'(S_BAD)};
      nst = 2'(S_BAD);
    end else if (delay >= TMO) begin
      r = {32'd0, 8'd0, op, 8'(TMO), 2'(S_TMO)};
      nst = 2'(S_TMO);
    end else begin
      r = {outp, exc, op, 8'(delay), (delay == spec_latency(op)) ? 2'(S_OK) : 2'(S_MISM)};
      nst = 2'(S_OK);
    end
    exp_q.push_back(r);
    exp_nochk_q.push_back(nst);
  endtask

  // One full transaction; entered and left at a negedge with the DUT idle.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] rm, input int delay, input logic [W-1:0] outp,
                        input logic [7:0] exc, input int hold, input bit late_ready);
    logic [RW-1:0] e, act;
    logic [1:0] en;
    int k;
    predict(op, delay, outp, exc);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_opa = a; cmd_opb = b; cmd_op = op; cmd_rmode = rm;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_opa = $urandom; cmd_opb = $urandom;
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    if (op < 3'd5) begin
      check("start_pulse", 64'(fpu_start), 64'd1);
      if (have_hs) check("restart_gap", 64'(cycle - hs_cycle), 64'd2);
      check("fpu_operands", {fpu_opa, fpu_opb}, {a, b});
      check("fpu_op_rmode", 64'({fpu_op, fpu_rmode}), 64'({op, rm}));
      k = 0;
      while (k < 100) begin
        @(negedge clk);
        k++;
        fpu_ready = 1'b0;
        fpu_outp = $urandom;
        fpu_exc = 8'($urandom);
        if (rsp_valid) break;
        if (fpu_start) check("no_second_start", 64'(fpu_start), 64'd0);
        if (fpu_op != op) check("fpu_op_held", 64'(fpu_op), 64'(op));
        if (k == delay + 1 && delay < TMO) begin
          fpu_ready = 1'b1; fpu_outp = outp; fpu_exc = exc;
        end
      end
      if (k >= 100) check("rsp_wait_bound", 64'(rsp_valid), 64'd1);
    end else begin
      check("bad_no_start", 64'(fpu_start), 64'd0);
      check("bad_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    e = exp_q.pop_front();
    en = exp_nochk_q.pop_front();
    check("rsp_result", 64'(rsp_result), 64'(e[RW-1 -: W]));
    check("rsp_exc", 64'(rsp_exc), 64'(e[20:13]));
    check("rsp_op", 64'(rsp_op), 64'(e[12:10]));
    check("rsp_latency", 64'(rsp_latency), 64'(e[9:2]));
    check("rsp_status", 64'(rsp_status), 64'(e[1:0]));
    check("nochk_status", 64'(n_rsp_status), 64'(en));
    check("spurious", 64'(spurious_ready), 64'(exp_spur));
    if (late_ready) begin
      fpu_ready = 1'b1;
      exp_spur = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      fpu_ready = 1'b0;
      act = {rsp_result, rsp_exc, rsp_op, rsp_latency, rsp_status};
      check("rsp_stable", 64'(act), 64'(e));
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_busy", 64'({cmd_ready, fpu_start}), 64'd0);
    end
    rsp_ready = 1'b1;
    hs_cycle = cycle;
    have_hs = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    fpu_ready = 1'b0;
    check("post_hs", 64'({rsp_valid, cmd_ready}), 64'b01);
    check("spurious_post", 64'(spurious_ready), 64'(exp_spur));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [2:0] op;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_fpu", {fpu_opa, 27'd0, fpu_op, fpu_rmode}, 64'd0);
    check("rst_rsp", {rsp_result, rsp_exc, 8'd0, rsp_latency, 5'd0, rsp_op, rsp_status},
          64'd0);
    check("rst_flags", 64'({fpu_start, rsp_valid, spurious_ready}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'h3F800000, 32'h40000000, 2'd0, 7, 32'h40400000, 8'h00, 0, 1'b0);
    run_op(3'd2, 32'h40000000, 32'h40400000, 2'd1, 11, 32'h40C00000, 8'h80, 1, 1'b0);
    run_op(3'd5, 32'h12345678, 32'h9ABCDEF0, 2'd2, 0, 32'd0, 8'd0, 0, 1'b0);
    run_op(3'd4, 32'h40800000, 32'd0, 2'd0, 35, 32'h40000000, 8'h01, 5, 1'b0);
    run_op(3'd0, 32'hBF800000, 32'h3F800000, 2'd3, 7, 32'h00000000, 8'h04, 0, 1'b0);

    for (int n = 0; n < 14; n++) begin
      op = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 2) == 0) ? spec_latency(op) : int'($urandom_range(0, 62));
      run_op(op, $urandom, $urandom, 2'($urandom_range(0, 3)), d, $urandom,
             8'($urandom), $urandom_range(0, 3), 1'b0);
    end

    run_op(3'd3, 32'h3F800000, 32'h00000000, 2'd0, TMO, 32'd0, 8'd0, 2, 1'b1);
    repeat (3) @(negedge clk);
    check("spurious_sticky", 64'(spurious_ready), 64'd1);

    // Abandon a divide mid-flight with reset.
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_opa = 32'h41200000; cmd_opb = 32'h40000000;
    cmd_rmode = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_spur = 1'b0;
    have_hs = 1'b0;
    check("mid_rst_fpu", {fpu_opa, 27'd0, fpu_op, fpu_rmode}, 64'd0);
    check("mid_rst_flags", 64'({fpu_start, rsp_valid, spurious_ready, cmd_ready}), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || fpu_start) check("no_rsp_after_rst", 64'({rsp_valid, fpu_start}), 64'd0);
    end
    run_op(3'd0, 32'h3F800000, 32'h3F800000, 2'd0, 7, 32'h40000000, 8'h00, 1, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
